// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC, multiplexed 3-nibble ROM address bus, 2-nibble fetch with valid/ack handoff.
// Optional ADDR_STACK_EN adds a 3-entry circular return stack (push/pop in WAIT).
`default_nettype none

module instruction_fetch_unit #(
    parameter int                  PC_WIDTH = 12,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk_2,
    input  logic                reset,
    input  logic [3:0]          rom_data,
    input  logic                ir_ack,
    input  logic                jump_req,
    input  logic [PC_WIDTH-1:0] jump_addr,
    input  logic                push_req,
    input  logic                pop_req,
    output logic [3:0]          addr_nibble,
    output logic                sync,
    output logic [2:0]          phase,
    output logic [PC_WIDTH-1:0] pc,
    output logic [7:0]          instruction,
    output logic                instr_valid
);

    typedef enum logic [2:0] {
        A1   = 3'd0,
        A2   = 3'd1,
        A3   = 3'd2,
        M1   = 3'd3,
        M2   = 3'd4,
        WAIT = 3'd5
    } state_t;

    state_t              state;
    logic [3:0]          opr;
    logic [PC_WIDTH-1:0] pc_inc;
    logic                fetch_go;
    logic [PC_WIDTH-1:0] fetch_pc;

    function automatic logic [3:0] nib(input logic [PC_WIDTH-1:0] v, input int idx);
        return 4'(v >> (4 * idx));
    endfunction

    assign pc_inc = pc + PC_WIDTH'(1);
    assign phase  = state;

`ifdef ADDR_STACK_EN
    logic [PC_WIDTH-1:0] stack [3];
    logic [1:0]          ptr;
    logic [1:0]          ptr_next;
    logic [1:0]          ptr_prev;

    assign ptr_next = (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
    assign ptr_prev = (ptr == 2'd0) ? 2'd2 : ptr - 2'd1;
`else
    logic unused_stack_reqs;
    assign unused_stack_reqs = push_req | pop_req;
`endif

    // WAIT-state exit decision: jump > push > pop > ack.
    always_comb begin
        fetch_go = 1'b0;
        fetch_pc = pc;
        if (state == WAIT) begin
            if (jump_req) begin
                fetch_go = 1'b1;
                fetch_pc = jump_addr;
            end
`ifdef ADDR_STACK_EN
            else if (push_req) begin
                fetch_go = 1'b1;
                fetch_pc = jump_addr;
            end else if (pop_req) begin
                fetch_go = 1'b1;
                fetch_pc = stack[ptr_prev];
            end
`endif
            else if (ir_ack) begin
                fetch_go = 1'b1;
            end
        end
    end

    // addr_nibble and sync are registered from the state being entered.
    always_ff @(posedge clk_2 or negedge reset) begin
        if (!reset) begin
            state       <= A1;
            pc          <= RESET_PC;
            instruction <= 8'h00;
            instr_valid <= 1'b0;
            addr_nibble <= 4'h0;
            sync        <= 1'b0;
            opr         <= 4'h0;
`ifdef ADDR_STACK_EN
            ptr         <= 2'd0;
            for (int i = 0; i < 3; i++) begin
                stack[i] <= RESET_PC;
            end
`endif
        end else begin
            case (state)
                A1: begin
                    state       <= A2;
                    addr_nibble <= nib(pc, 1);
                    sync        <= 1'b0;
                end
                A2: begin
                    state       <= A3;
                    addr_nibble <= nib(pc, 2);
                end
                A3: begin
                    state       <= M1;
                    addr_nibble <= 4'h0;
                end
                M1: begin
                    state <= M2;
                    opr   <= rom_data;
                end
                M2: begin
                    state       <= WAIT;
                    instruction <= {opr, rom_data};
                    instr_valid <= 1'b1;
                    pc          <= pc_inc;
                end
                WAIT: begin
                    if (fetch_go) begin
                        state       <= A1;
                        pc          <= fetch_pc;
                        instr_valid <= 1'b0;
                        addr_nibble <= nib(fetch_pc, 0);
                        sync        <= 1'b1;
                    end
`ifdef ADDR_STACK_EN
                    if (!jump_req && push_req) begin
                        stack[ptr] <= pc;
                        ptr        <= ptr_next;
                    end else if (!jump_req && pop_req) begin
                        ptr <= ptr_prev;
                    end
`endif
                end
                default: begin
                    state       <= A1;
                    addr_nibble <= nib(pc, 0);
                    sync        <= 1'b1;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: randomized fetch/jump/ack traffic checked against a transaction-level model
// (ROM image array, expected PC, optional return-stack array).
`default_nettype none

module tb_instruction_fetch_unit;

    logic        clk_2;
    logic        reset;
    logic [3:0]  rom_data;
    logic        ir_ack;
    logic        jump_req;
    logic [11:0] jump_addr;
    logic        push_req;
    logic        pop_req;
    logic [3:0]  addr_nibble;
    logic        sync;
    logic [2:0]  phase;
    logic [11:0] pc;
    logic [7:0]  instruction;
    logic        instr_valid;

    instruction_fetch_unit #(.PC_WIDTH(12), .RESET_PC(12'h000)) dut (
        .clk_2       (clk_2),
        .reset       (reset),
        .rom_data    (rom_data),
        .ir_ack      (ir_ack),
        .jump_req    (jump_req),
        .jump_addr   (jump_addr),
        .push_req    (push_req),
        .pop_req     (pop_req),
        .addr_nibble (addr_nibble),
        .sync        (sync),
        .phase       (phase),
        .pc          (pc),
        .instruction (instruction),
        .instr_valid (instr_valid)
    );

    initial begin
        clk_2 = 1'b0;
        forever #5 clk_2 = ~clk_2;
    end

    int total = 0;
    int bad   = 0;

    logic [7:0]  rom [4096];
    logic [11:0] m_pc;
    logic [7:0]  m_instr;
    logic [11:0] m_stack [3];
    int          m_ptr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_2);
        #1;
    endtask

    task automatic junk_inputs();
        ir_ack    = 1'($urandom);
        jump_req  = 1'($urandom);
        push_req  = 1'($urandom);
        pop_req   = 1'($urandom);
        jump_addr = 12'($urandom);
    endtask

    task automatic clear_inputs();
        ir_ack = 0; jump_req = 0; push_req = 0; pop_req = 0;
    endtask

    task automatic model_reset();
        m_pc    = 12'h000;
        m_instr = 8'h00;
        m_ptr   = 0;
        for (int i = 0; i < 3; i++) m_stack[i] = 12'h000;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_phase", 32'(phase), 0);
        chk("rst_pc", 32'(pc), 0);
        chk("rst_instr", 32'(instruction), 0);
        chk("rst_valid", 32'(instr_valid), 0);
        chk("rst_sync", 32'(sync), 0);
        chk("rst_nib", 32'(addr_nibble), 0);
    endtask

    // Entered with the DUT in A1 about to fetch from addr; leaves it in WAIT.
    task automatic do_fetch(input logic [11:0] addr, input bit first);
        logic [3:0] exp_nib [3];
        exp_nib[0] = first ? 4'h0 : addr[3:0];
        exp_nib[1] = addr[7:4];
        exp_nib[2] = addr[11:8];
        for (int p = 0; p < 5; p++) begin
            chk("f_phase", 32'(phase), 32'(p));
            chk("f_sync", 32'(sync), (p == 0 && !first) ? 1 : 0);
            chk("f_nib", 32'(addr_nibble), (p < 3) ? 32'(exp_nib[p]) : 0);
            chk("f_pc", 32'(pc), 32'(addr));
            chk("f_valid", 32'(instr_valid), 0);
            chk("f_instr_hold", 32'(instruction), 32'(m_instr));
            junk_inputs();
            rom_data = (p == 3) ? rom[addr][7:4] : (p == 4) ? rom[addr][3:0] : 4'($urandom);
            tick();
        end
        clear_inputs();
        m_instr = rom[addr];
        m_pc    = addr + 12'd1;
        chk("w_phase", 32'(phase), 5);
        chk("w_instr", 32'(instruction), 32'(m_instr));
        chk("w_valid", 32'(instr_valid), 1);
        chk("w_pc", 32'(pc), 32'(m_pc));
        chk("w_sync", 32'(sync), 0);
        chk("w_nib", 32'(addr_nibble), 0);
    endtask

    // kind: 0 ack, 1 jump, 2 push, 3 pop. Holds in WAIT first, then leaves and fetches.
    task automatic act(input int hold, input int kind, input logic [11:0] jaddr, input bit ack_too);
        logic [11:0] nxt;
        for (int i = 0; i < hold; i++) begin
            clear_inputs();
`ifndef ADDR_STACK_EN
            push_req = 1'($urandom);
            pop_req  = 1'($urandom);
`endif
            jump_addr = 12'($urandom);
            tick();
            chk("hold_phase", 32'(phase), 5);
            chk("hold_valid", 32'(instr_valid), 1);
            chk("hold_instr", 32'(instruction), 32'(m_instr));
            chk("hold_pc", 32'(pc), 32'(m_pc));
            chk("hold_sync", 32'(sync), 0);
        end
        clear_inputs();
        ir_ack    = ack_too;
        jump_addr = jaddr;
        nxt       = m_pc;
        case (kind)
            1: begin jump_req = 1; nxt = jaddr; end
`ifdef ADDR_STACK_EN
            2: begin
                push_req = 1;
                pop_req  = 1'($urandom);
                m_stack[m_ptr] = m_pc;
                m_ptr = (m_ptr + 1) % 3;
                nxt = jaddr;
            end
            3: begin
                pop_req = 1;
                m_ptr = (m_ptr + 2) % 3;
                nxt = m_stack[m_ptr];
            end
`endif
            default: ir_ack = 1;
        endcase
        tick();
        clear_inputs();
        chk("go_phase", 32'(phase), 0);
        chk("go_valid", 32'(instr_valid), 0);
        chk("go_pc", 32'(pc), 32'(nxt));
        do_fetch(nxt, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4096; i++) rom[i] = 8'($urandom);
        rom[0] = 8'hA3;
        clear_inputs();
        jump_addr = 12'h000;
        rom_data  = 4'h0;
        model_reset();
        reset = 1'b0;
        tick(); tick();
        chk_reset_outputs();
        reset = 1'b1;

        do_fetch(12'h000, 1);
        chk("first_instr_a3", 32'(instruction), 32'hA3);
        act(10, 0, 12'h000, 0);
        act(2, 1, 12'h5C7, 1);
        chk("jump_pc_5c8", 32'(pc), 32'h5C8);
        act(1, 1, 12'hFFF, 0);
        chk("wrap_pc", 32'(pc), 32'h000);
        act(0, 0, 12'h000, 0);

        // Reset asserted mid-fetch (M1).
        ir_ack = 1;
        tick();
        clear_inputs();
        tick(); tick(); tick();
        chk("m1_phase", 32'(phase), 3);
        rom_data = 4'h5;
        reset = 1'b0;
        #1;
        chk_reset_outputs();
        #2;
        reset = 1'b1;
        model_reset();
        do_fetch(12'h000, 1);

`ifdef ADDR_STACK_EN
        act(0, 1, 12'h00F, 0);
        act(0, 2, 12'h200, 0);
        act(0, 3, 12'h000, 0);
        act(0, 0, 12'h000, 0);
        for (int i = 0; i < 4; i++) act(0, 2, 12'(12'h300 + 16 * i), 0);
        for (int i = 0; i < 3; i++) act(0, 3, 12'h000, 0);
`endif

        for (int n = 0; n < 30; n++) begin
            int          kind;
            logic [11:0] ja;
`ifdef ADDR_STACK_EN
            kind = int'($urandom_range(0, 3));
`else
            kind = int'($urandom_range(0, 1));
`endif
            ja = ($urandom_range(0, 3) == 0) ? 12'hFFF : 12'($urandom);
            act(int'($urandom_range(0, 4)), kind, ja, 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
